// File: rtl/ex_trap_arbiter.sv
// Round-robin arbiter serialising NUM_SRC interrupt sources onto the core's
// single external-trap valid/ready handshake, with per-source pending, enable and overflow.
module ex_trap_arbiter #(
    parameter int unsigned        NUM_SRC   = 8,
    parameter int unsigned        ID_W      = 3,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = 8'hFF,
    parameter logic [NUM_SRC-1:0] EN_RST    = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic               cfg_en_we,
    input  logic [NUM_SRC-1:0] cfg_en_wdata,
    input  logic [NUM_SRC-1:0] ovf_clr,
    output logic [NUM_SRC-1:0] en_o,
    output logic [NUM_SRC-1:0] pending_o,
    output logic [NUM_SRC-1:0] ovf_o,
    output logic               core_ex_trap_valid,
    input  logic               core_ex_trap_ready,
    output logic [ID_W-1:0]    trap_id
);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] edge_ev;
    logic [NUM_SRC-1:0] set_ev;
    logic [NUM_SRC-1:0] grant_clr;
    logic [NUM_SRC-1:0] req;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_next;
    logic [ID_W-1:0]    pick;
    logic [ID_W-1:0]    idx;
    logic               found;

    always_comb begin
        edge_ev   = src_req & ~prev;
        set_ev    = (EDGE_MASK & edge_ev) | (~EDGE_MASK & src_req);
        grant_clr = '0;
        if (state == REQ && core_ex_trap_ready)
            grant_clr[trap_id] = 1'b1;
        rr_next = (trap_id == ID_W'(NUM_SRC - 1)) ? '0 : trap_id + 1'b1;
    end

    // First requesting source at or above rr_ptr, wrapping around.
    always_comb begin
        req   = pending_o & en_o;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = ID_W'((32'(rr_ptr) + k) % NUM_SRC);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            core_ex_trap_valid <= 1'b0;
            trap_id            <= '0;
            rr_ptr             <= '0;
            prev               <= '0;
            pending_o          <= '0;
            ovf_o              <= '0;
            en_o               <= EN_RST;
        end else begin
            prev      <= src_req;
            // A new set event in the grant cycle keeps the source pending.
            pending_o <= (pending_o & ~grant_clr) | set_ev;
            ovf_o     <= (ovf_o & ~ovf_clr) | (EDGE_MASK & edge_ev & pending_o);
            if (cfg_en_we)
                en_o <= cfg_en_wdata;

            case (state)
                IDLE: begin
                    if (found) begin
                        trap_id            <= pick;
                        core_ex_trap_valid <= 1'b1;
                        state              <= REQ;
                    end
                end
                REQ: begin
                    if (core_ex_trap_ready) begin
                        core_ex_trap_valid <= 1'b0;
                        rr_ptr             <= rr_next;
                        state              <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
